// File: rtl/dcache_flush_walker.sv
// Write-back D$ flush walker: visits every (set, way), writes back dirty lines,
// invalidates valid lines, then pulses a single flush acknowledge.
module dcache_flush_walker #(
    parameter int unsigned NR_SETS = 256,
    parameter int unsigned NR_WAYS = 8,
    parameter int unsigned TAG_W   = 44,
    localparam int unsigned SET_W  = $clog2(NR_SETS),
    localparam int unsigned WAY_W  = $clog2(NR_WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    output logic             flush_ack_o,
    output logic             busy_o,
    output logic             meta_req_o,
    output logic [SET_W-1:0] meta_set_o,
    output logic [WAY_W-1:0] meta_way_o,
    input  logic             meta_gnt_i,
    input  logic             meta_valid_i,
    input  logic             meta_dirty_i,
    input  logic [TAG_W-1:0] meta_tag_i,
    output logic             wb_valid_o,
    output logic [SET_W-1:0] wb_set_o,
    output logic [WAY_W-1:0] wb_way_o,
    output logic [TAG_W-1:0] wb_tag_o,
    input  logic             wb_ready_i,
    input  logic             wb_done_i,
    output logic             inv_req_o,
    output logic [SET_W-1:0] inv_set_o,
    output logic [WAY_W-1:0] inv_way_o,
    input  logic             inv_gnt_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWaitData,
        StWbReq,
        StWbWait,
        StInv,
        StAck
    } state_e;

    state_e             r_state, w_state_d;
    logic [SET_W-1:0]   r_set, w_set_d;
    logic [WAY_W-1:0]   r_way, w_way_d;
    logic [TAG_W-1:0]   r_tag, w_tag_d;
    logic               r_armed, w_armed_d;
    logic               w_advance;
    logic               w_last;

    assign w_last = (r_set == SET_W'(NR_SETS - 1)) && (r_way == WAY_W'(NR_WAYS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_set   <= '0;
            r_way   <= '0;
            r_tag   <= '0;
            r_armed <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_set   <= w_set_d;
            r_way   <= w_way_d;
            r_tag   <= w_tag_d;
            r_armed <= w_armed_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_set_d   = r_set;
        w_way_d   = r_way;
        w_tag_d   = r_tag;
        w_armed_d = r_armed;
        w_advance = 1'b0;

        // A low sample re-arms; ACK below overrides so a held request cannot re-trigger.
        if (!flush_i) begin
            w_armed_d = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                w_set_d = '0;
                w_way_d = '0;
                if (flush_i && r_armed) begin
                    w_state_d = StRead;
                end
            end
            StRead: begin
                if (meta_gnt_i) begin
                    w_state_d = StWaitData;
                end
            end
            StWaitData: begin
                w_tag_d = meta_tag_i;
                if (!meta_valid_i) begin
                    w_advance = 1'b1;
                end else if (meta_dirty_i) begin
                    w_state_d = StWbReq;
                end else begin
                    w_state_d = StInv;
                end
            end
            StWbReq: begin
                if (wb_ready_i) begin
                    w_state_d = StWbWait;
                end
            end
            StWbWait: begin
                if (wb_done_i) begin
                    w_state_d = StInv;
                end
            end
            StInv: begin
                if (inv_gnt_i) begin
                    w_advance = 1'b1;
                end
            end
            StAck: begin
                w_armed_d = 1'b0;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Way is the low field, so one increment of {set, way} wraps way and carries into set.
        if (w_advance) begin
            if (w_last) begin
                w_state_d = StAck;
            end else begin
                {w_set_d, w_way_d} = {r_set, r_way} + (SET_W + WAY_W)'(1);
                w_state_d = StRead;
            end
        end
    end

    assign busy_o      = (r_state != StIdle);
    assign flush_ack_o = (r_state == StAck);

    assign meta_req_o  = (r_state == StRead);
    assign meta_set_o  = meta_req_o ? r_set : '0;
    assign meta_way_o  = meta_req_o ? r_way : '0;

    assign wb_valid_o  = (r_state == StWbReq);
    assign wb_set_o    = wb_valid_o ? r_set : '0;
    assign wb_way_o    = wb_valid_o ? r_way : '0;
    assign wb_tag_o    = wb_valid_o ? r_tag : '0;

    assign inv_req_o   = (r_state == StInv);
    assign inv_set_o   = inv_req_o ? r_set : '0;
    assign inv_way_o   = inv_req_o ? r_way : '0;

endmodule
